// File: rtl/inv_s_box.sv
// rtl/inv_s_box.sv - word-wide AES inverse S-box, four independent byte lookups
//
// Ports:
//   in  [31:0]  four input bytes
//   out [31:0]  InvSubBytes of each byte, same byte positions as in
module inv_s_box (
    input  logic [31:0] in,
    output logic [31:0] out
);

    // Entry x sits at bits [8*(255-x)+7 -: 8], i.e. index {~x, 3'b111}.
    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign out[8*b +: 8] = INV_TABLE[{~in[8*b +: 8], 3'b111} -: 8];
    end

endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - multi-cycle AES-128 inverse cipher, one inverse step per clock
//
// Ports:
//   clk      clock, all state changes on rising edge
//   reset    synchronous active-high reset
//   w        11 round keys; round r word c = w[128*r + 32*c +: 32]
//   in       ciphertext; column c = in[127-32*c -: 32], row r = bits [31-8*r -: 8]
//   out      plaintext, packed like in; written when the block finishes
//   trigger  level start request, only looked at while idle
//   done     high once out is valid; sticky until reset
module aes_decrypt (
    input  logic          clk,
    input  logic          reset,
    input  logic [1407:0] w,
    input  logic [127:0]  in,
    output logic [127:0]  out,
    input  logic          trigger,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        ADD    = 3'd2,
        IMIX   = 3'd3,
        ISHIFT = 3'd4,
        ISUB   = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] col [4];
    logic [3:0]  round_num;

    logic [31:0]  sub_col     [4];
    logic [31:0]  shifted_col [4];
    logic [31:0]  mixed_col   [4];
    logic [31:0]  keyed_col   [4];
    logic [127:0] round_key;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiplier k in GF(2^8), assembled from x, 2x, 4x, 8x.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // round_num only reaches 11..15 after the final ADD, where the key is unused.
    always_comb begin
        round_key = '0;
        for (int r = 0; r < 11; r++) begin
            if (round_num == r[3:0]) begin
                round_key = w[128*r +: 128];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_s_box u_inv_s_box (
            .in  (col[c]),
            .out (sub_col[c])
        );

        // Row r of new column c comes from old column (c - r) mod 4.
        assign shifted_col[c] = {col[c][31:24],
                                 col[(c + 3) % 4][23:16],
                                 col[(c + 2) % 4][15:8],
                                 col[(c + 1) % 4][7:0]};

        assign mixed_col[c] = inv_mix_col(col[c]);
        assign keyed_col[c] = col[c] ^ round_key[32*c +: 32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            out       <= '0;
            round_num <= '0;
            for (int c = 0; c < 4; c++) begin
                col[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (trigger) begin
                        state <= START;
                    end
                end
                START: begin
                    for (int c = 0; c < 4; c++) begin
                        col[c] <= in[127 - 32*c -: 32];
                    end
                    round_num <= 4'd10;
                    done      <= 1'b0;
                    state     <= ADD;
                end
                ADD: begin
                    col       <= keyed_col;
                    round_num <= round_num - 4'd1;
                    // The first key add skips InvMixColumns; the last one ends the block.
                    if (round_num == 4'd10) begin
                        state <= ISHIFT;
                    end else if (round_num == 4'd0) begin
                        state <= DONE;
                    end else begin
                        state <= IMIX;
                    end
                end
                IMIX: begin
                    col   <= mixed_col;
                    state <= ISHIFT;
                end
                ISHIFT: begin
                    col   <= shifted_col;
                    state <= ISUB;
                end
                ISUB: begin
                    col   <= sub_col;
                    state <= ADD;
                end
                DONE: begin
                    out  <= {col[0], col[1], col[2], col[3]};
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - directed and loopback checks for aes_decrypt
module tb_aes_decrypt;

    logic          clk;
    logic          reset;
    logic [1407:0] w;
    logic [127:0]  in_blk;
    logic [127:0]  out_blk;
    logic          trigger;
    logic          done;

    int checks;
    int failures;

    logic [7:0] sbox [256];

    aes_decrypt dut (
        .clk     (clk),
        .reset   (reset),
        .w       (w),
        .in      (in_blk),
        .out     (out_blk),
        .trigger (trigger),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    // Forward S-box from the field inverse and the affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] b, s, r;
        b = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gf_mul(x, 8'(y)) == 8'h01) b = 8'(y);
        end
        s = b;
        r = b;
        for (int i = 0; i < 4; i++) begin
            r = rotl1(r);
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[32*i +: 32] = wd[i];
        return res;
    endfunction

    function automatic logic [127:0] rkey(input logic [1407:0] ww, input int r);
        logic [127:0] k;
        for (int c = 0; c < 4; c++) k[127 - 32*c -: 32] = ww[128*r + 32*c +: 32];
        return k;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ww);
        logic [127:0] st, ns;
        logic [7:0]   a0, a1, a2, a3;
        st = pt ^ rkey(ww, 0);
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) st[8*i +: 8] = sbox[st[8*i +: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    ns[127 - 32*c - 8*r -: 8] = st[127 - 32*((c + r) % 4) - 8*r -: 8];
            st = ns;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[127 - 32*c -: 8];
                    a1 = st[119 - 32*c -: 8];
                    a2 = st[111 - 32*c -: 8];
                    a3 = st[103 - 32*c -: 8];
                    st[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
            end
            st = st ^ rkey(ww, rnd);
        end
        return st;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        trigger = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Trigger sampled at E0; counts edges until done, bounded at 60.
    task automatic run_block(input logic [127:0] ct, input logic [1407:0] ww, input bit hold,
                             input logic [127:0] exp, input string tag);
        int edge_n;
        edge_n = 0;
        @(negedge clk);
        in_blk  = ct;
        w       = ww;
        trigger = 1'b1;
        @(posedge clk);
        while (edge_n < 60) begin
            @(posedge clk);
            edge_n++;
            #1;
            if (hold && edge_n == 1) in_blk = '1;
            if (!hold) trigger = 1'b0;
            if (done) break;
        end
        check({tag, " latency"}, 128'(edge_n), 128'd42);
        check({tag, " out"}, out_blk, exp);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [1407:0] w_c1, w_rand;
        logic [127:0]  key, pt, held;
        int            bad;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        trigger  = 1'b0;
        w        = '0;
        in_blk   = '0;

        for (int i = 0; i < 256; i++) sbox[i] = calc_sbox(8'(i));
        w_c1 = expand_key(C1_KEY);

        do_reset();
        #1;
        check("reset done", 128'(done), 128'd0);
        check("reset out", out_blk, 128'h0);
        check("reset state", 128'(dut.state), 128'd0);

        run_block(C1_CT, w_c1, 1'b0, C1_PT, "c1");

        do_reset();
        run_block(B_CT, expand_key(B_KEY), 1'b0, B_PT, "appb");

        // Abort 20 edges after trigger sampling.
        do_reset();
        @(negedge clk);
        in_blk  = C1_CT;
        w       = w_c1;
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort done", 128'(done), 128'd0);
        check("abort out", out_blk, 128'h0);
        check("abort state", 128'(dut.state), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        run_block(C1_CT, w_c1, 1'b0, C1_PT, "after abort");

        // Trigger held high throughout, in corrupted after START.
        do_reset();
        run_block(C1_CT, w_c1, 1'b1, C1_PT, "hold");
        held = out_blk;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1 || out_blk !== held) bad++;
        end
        check("sticky cycles bad", 128'(bad), 128'd0);
        check("sticky out", out_blk, C1_PT);
        trigger = 1'b0;

        // Reset and trigger on the same edge.
        @(negedge clk);
        reset   = 1'b1;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        check("prio state", 128'(dut.state), 128'd0);
        check("prio done", 128'(done), 128'd0);
        @(negedge clk);
        reset   = 1'b0;
        trigger = 1'b0;
        @(posedge clk);
        #1;
        check("prio idle after", 128'(dut.state), 128'd0);

        for (int n = 0; n < 100; n++) begin
            key    = {$urandom, $urandom, $urandom, $urandom};
            pt     = {$urandom, $urandom, $urandom, $urandom};
            w_rand = expand_key(key);
            do_reset();
            run_block(encrypt(pt, w_rand), w_rand, 1'b0, pt, $sformatf("loop%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
